// File: rtl/chart_sequencer_pkg.sv
// Shared chart/record types for the rhythm-game storage managers, plus the
// sequencer state encoding and small helpers used by chart_sequencer.
package chart_sequencer_pkg;

  localparam logic [7:0] CHARTS_MAX = 8'd4;
  localparam int         NOTES_MAX  = 16;
  localparam int         NOTE_IDX_W = $clog2(NOTES_MAX);
  localparam int         SCORE_W    = 16;

  typedef logic [8:0] Notes;

  localparam Notes NOTE_NONE = 9'b0;

  typedef struct packed {
    logic [31:0] name;
    logic [7:0]  note_cnt;
  } ChartInfo;

  typedef struct packed {
    ChartInfo                   info;
    Notes [NOTES_MAX-1:0]       notes;
  } Chart;

  typedef struct packed {
    logic [7:0]         user_id;
    logic [31:0]        name;
    logic [SCORE_W-1:0] score;
  } PlayRecord;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PLAY,
    ST_WRITE,
    ST_DONE
  } seq_state_t;

  // Indices past the stored note array read as silence rather than X.
  function automatic Notes note_at(input Chart c, input logic [8:0] idx);
    if (idx < 9'(NOTES_MAX)) return c.notes[idx[NOTE_IDX_W-1:0]];
    return NOTE_NONE;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/chart_sequencer_step.sv
// step_timer: free-running divider producing a one-cycle step_end pulse every
// TICK_DIV enabled cycles; a synchronous clear restarts the step.
module step_timer #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic step_end
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign step_end = en && (cnt == LAST);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= step_end ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: fetches one chart, steps its notes at a fixed tick rate,
// scores key hits and writes a single PlayRecord when the chart ends.
module chart_sequencer
  import chart_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int HIT_PTS  = 10
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         chart_sel,
  input  logic [7:0]         user_id,
  input  logic [7:0]         rec_slot,
  input  Notes               keys,
  output logic [7:0]         read_chart_id,
  input  Chart               current_chart_data,
  output logic [7:0]         write_record_id,
  output PlayRecord          new_record_data,
  output Notes               cur_note,
  output Notes               next_note,
  output logic [7:0]         note_idx,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  localparam logic [SCORE_W-1:0] HIT_INC = SCORE_W'(HIT_PTS);

  seq_state_t         state, state_nxt;
  logic [7:0]         sel_q, user_q, slot_q;
  logic [7:0]         note_cnt;
  logic [8:0]         idx_p1;
  logic               hit_q, hit_now, step_end, start_ok, last_step, play;
  logic [SCORE_W-1:0] score_step;

  assign note_cnt   = current_chart_data.info.note_cnt;
  assign start_ok   = start && (chart_sel != 8'd0) && (chart_sel <= CHARTS_MAX);
  assign play       = (state == ST_PLAY);
  assign last_step  = (note_idx == note_cnt - 8'd1);
  assign idx_p1     = {1'b0, note_idx} + 9'd1;
  assign hit_now    = play && (keys == cur_note) && (cur_note != NOTE_NONE);
  // A hit in the step's final cycle still belongs to that step.
  assign score_step = (step_end && (hit_q || hit_now)) ? sat_add(score, HIT_INC) : score;

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .en        (play),
    .clr       (!play),
    .step_end  (step_end)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_REQ;
      ST_REQ:   state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = (note_cnt == 8'd0) ? ST_WRITE : ST_PLAY;
      ST_PLAY:  if (step_end && last_step) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // Abort gates the write strobe and done in the same cycle so a late abort
  // never lets the record manager commit.
  always_comb begin
    busy            = (state != ST_IDLE);
    read_chart_id   = 8'd0;
    write_record_id = 8'd0;
    done            = 1'b0;
    cur_note        = NOTE_NONE;
    next_note       = NOTE_NONE;
    if (state == ST_REQ)             read_chart_id   = sel_q;
    if (state == ST_WRITE && !abort) write_record_id = slot_q;
    if (state == ST_DONE && !abort)  done            = 1'b1;
    if (play) begin
      cur_note = note_at(current_chart_data, {1'b0, note_idx});
      if (idx_p1 < {1'b0, note_cnt}) next_note = note_at(current_chart_data, idx_p1);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q           <= 8'd0;
      user_q          <= 8'd0;
      slot_q          <= 8'd0;
      note_idx        <= 8'd0;
      score           <= '0;
      hit_q           <= 1'b0;
      new_record_data <= '0;
    end else if (state == ST_IDLE) begin
      if (start_ok) begin
        sel_q    <= chart_sel;
        user_q   <= user_id;
        slot_q   <= rec_slot;
        note_idx <= 8'd0;
        score    <= '0;
        hit_q    <= 1'b0;
      end
    end else if (abort) begin
      note_idx <= 8'd0;
      score    <= '0;
      hit_q    <= 1'b0;
    end else begin
      if (play) begin
        score <= score_step;
        hit_q <= step_end ? 1'b0 : (hit_q | hit_now);
        if (step_end && !last_step) note_idx <= note_idx + 8'd1;
      end
      // Capture on entry to WRITE so the record is already stable in that cycle.
      if (state_nxt == ST_WRITE && state != ST_WRITE)
        new_record_data <= '{user_id: user_q,
                             name:    current_chart_data.info.name,
                             score:   score_step};
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer: behavioural chart/record managers
// and a per-step hit model derived from the key stream the bench drives.
module tb_chart_sequencer;
  import chart_sequencer_pkg::*;

  localparam int   TD = 4;
  localparam int   HP = 10;
  localparam Notes C4 = 9'h001;
  localparam Notes E4 = 9'h004;
  localparam Notes G4 = 9'h010;

  logic               clk = 1'b0;
  logic               sys_rst_n;
  logic               start, abort;
  logic [7:0]         chart_sel, user_id, rec_slot;
  Notes               keys;
  logic [7:0]         read_chart_id;
  Chart               current_chart_data = '0;
  logic [7:0]         write_record_id;
  PlayRecord          new_record_data;
  Notes               cur_note, next_note;
  logic [7:0]         note_idx;
  logic [SCORE_W-1:0] score;
  logic               busy, done;

  int n_checks = 0;
  int n_errors = 0;

  Chart      charts  [0:255];
  PlayRecord rec_mem [0:255];
  int        wr_count = 0;

  chart_sequencer #(.TICK_DIV(TD), .HIT_PTS(HP)) dut (
    .clk                (clk),
    .sys_rst_n          (sys_rst_n),
    .start              (start),
    .abort              (abort),
    .chart_sel          (chart_sel),
    .user_id            (user_id),
    .rec_slot           (rec_slot),
    .keys               (keys),
    .read_chart_id      (read_chart_id),
    .current_chart_data (current_chart_data),
    .write_record_id    (write_record_id),
    .new_record_data    (new_record_data),
    .cur_note           (cur_note),
    .next_note          (next_note),
    .note_idx           (note_idx),
    .score              (score),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  // Chart manager: registered lookup, holds while the id is 0.
  always @(posedge clk)
    if (read_chart_id != 8'd0) current_chart_data <= charts[read_chart_id];

  // Record manager: logs every committed write.
  always @(posedge clk)
    if (write_record_id != 8'd0) begin
      rec_mem[write_record_id] <= new_record_data;
      wr_count <= wr_count + 1;
    end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: no keys, 1: random keys, 2: keys follow the chart.
  // abort_step == note_cnt aborts in the WRITE cycle; -1 means no abort.
  task automatic run_chart(input logic [7:0] sel, input logic [7:0] user, input logic [7:0] slot,
                           input int mode, input int abort_step, input int abort_cyc);
    Chart      ch;
    PlayRecord exp_rec;
    int        cnt, exp_score, wr0, r;
    bit        hit, aborted;
    ch = charts[sel];
    cnt = int'(ch.info.note_cnt);
    wr0 = wr_count;
    exp_score = 0;
    aborted = 0;
    @(negedge clk);
    start = 1'b1; chart_sel = sel; user_id = user; rec_slot = slot; keys = NOTE_NONE;
    @(negedge clk);
    start = 1'b0;
    check("req_id", read_chart_id, sel);
    check("req_busy", busy, 1);
    @(negedge clk);
    check("wait_id", read_chart_id, 0);
    for (int s = 0; s < cnt && !aborted; s++) begin
      hit = 0;
      for (int c = 0; c < TD; c++) begin
        @(negedge clk);
        check("cur_note", cur_note, ch.notes[s]);
        check("next_note", next_note, (s < cnt - 1) ? ch.notes[s+1] : NOTE_NONE);
        check("note_idx", note_idx, s);
        if (c == 0) check("play_score", score, exp_score);
        r = $urandom_range(0, 3);
        case (mode)
          1:       keys = (r == 0) ? NOTE_NONE : (r == 1) ? ch.notes[s] : 9'($urandom);
          2:       keys = ch.notes[s];
          default: keys = NOTE_NONE;
        endcase
        if (keys == ch.notes[s] && ch.notes[s] != NOTE_NONE) hit = 1;
        if (s == abort_step && c == abort_cyc) begin
          abort = 1'b1;
          aborted = 1;
          break;
        end
      end
      if (hit && !aborted) exp_score += HP;
    end
    if (!aborted) begin
      @(negedge clk);
      keys = NOTE_NONE;
      exp_rec.user_id = user;
      exp_rec.name    = ch.info.name;
      exp_rec.score   = 16'(exp_score);
      check("write_score", score, exp_score);
      check("write_record", new_record_data, exp_rec);
      check("write_done", done, 0);
      if (abort_step == cnt) begin
        abort = 1'b1;
        aborted = 1;
        #1;
        check("abort_write_id", write_record_id, 0);
      end else begin
        check("write_id", write_record_id, slot);
      end
    end
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0; keys = NOTE_NONE;
      check("abort_busy", busy, 0);
      check("abort_score", score, 0);
      check("abort_done", done, 0);
      check("abort_read", read_chart_id, 0);
      check("abort_write", write_record_id, 0);
      check("abort_wr_count", wr_count, wr0);
      return;
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_write", write_record_id, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_score", score, exp_score);
    check("wr_count", wr_count, wr0 + ((slot != 8'd0) ? 1 : 0));
    if (slot != 8'd0) check("rec_mem", rec_mem[slot], exp_rec);
  endtask

  task automatic bad_start(input logic [7:0] sel);
    @(negedge clk);
    start = 1'b1; chart_sel = sel; user_id = 8'h11; rec_slot = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bad_busy", busy, 0);
      check("bad_read", read_chart_id, 0);
      check("bad_done", done, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    Chart ch;
    int   n;
    sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    chart_sel = 8'd0; user_id = 8'd0; rec_slot = 8'd0; keys = NOTE_NONE;
    for (int i = 0; i < 256; i++) begin
      charts[i]  = '0;
      rec_mem[i] = '0;
    end
    charts[1].info.name = 32'h4348_5431; charts[1].info.note_cnt = 8'd3;
    charts[1].notes[0] = C4; charts[1].notes[1] = NOTE_NONE; charts[1].notes[2] = G4;
    charts[3].info.name = 32'h4348_5433; charts[3].info.note_cnt = 8'd3;
    charts[3].notes[0] = E4; charts[3].notes[1] = E4; charts[3].notes[2] = E4;
    charts[4].info.name = 32'h454D_5054; charts[4].info.note_cnt = 8'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cur", cur_note, NOTE_NONE);
    check("rst_next", next_note, NOTE_NONE);
    check("rst_score", score, 0);
    check("rst_idx", note_idx, 0);
    check("rst_read", read_chart_id, 0);
    check("rst_write", write_record_id, 0);
    check("rst_record", new_record_data, 0);
    sys_rst_n = 1'b1;

    run_chart(8'd1, 8'h42, 8'd3, 2, -1, 0);
    run_chart(8'd1, 8'h43, 8'd3, 0, -1, 0);
    bad_start(8'd0);
    bad_start(CHARTS_MAX + 8'd1);
    run_chart(8'd1, 8'h44, 8'd2, 2, 1, 1);
    run_chart(8'd1, 8'h45, 8'd2, 2, 3, 0);
    run_chart(8'd4, 8'h46, 8'd5, 0, -1, 0);
    run_chart(8'd4, 8'h47, 8'd0, 0, -1, 0);
    run_chart(8'd3, 8'h48, 8'd6, 2, -1, 0);

    for (int it = 0; it < 6; it++) begin
      ch = '0;
      n = $urandom_range(1, 7);
      ch.info.name = 32'h524E_4430 + 32'(it);
      ch.info.note_cnt = 8'(n);
      for (int i = 0; i < n; i++)
        ch.notes[i] = ($urandom_range(0, 3) == 0) ? NOTE_NONE : Notes'(1 << $urandom_range(0, 8));
      charts[2] = ch;
      run_chart(8'd2, 8'($urandom), 8'($urandom_range(0, 5)), 1, -1, 0);
    end

    @(negedge clk);
    start = 1'b1; chart_sel = 8'd1; user_id = 8'h50; rec_slot = 8'd7;
    @(negedge clk);
    start = 1'b0; keys = C4;
    repeat (4) @(negedge clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cur", cur_note, NOTE_NONE);
    check("arst_next", next_note, NOTE_NONE);
    check("arst_score", score, 0);
    check("arst_idx", note_idx, 0);
    check("arst_record", new_record_data, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    keys = NOTE_NONE;
    sys_rst_n = 1'b1;
    run_chart(8'd1, 8'h51, 8'd3, 2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
